// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : instruction fetch with redirect, freeze, stall and i-miss  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MISS_CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           Alt_PC_IN,
    input  logic                  Request_Alt_PC_IN,
    input  logic                  WANT_FREEZE_IN,
    input  logic                  Stall_fmem_IN,
    output logic [31:0]           ICache_Addr_OUT,
    output logic                  ICache_Req_OUT,
    input  logic [31:0]           ICache_Data_IN,
    input  logic                  ICache_Hit_IN,
    input  logic                  ICache_Fill_Done_IN,
    output logic [31:0]           Instr1_OUT,
    output logic [31:0]           Instr_PC_OUT,
    output logic [31:0]           Instr_PC_Plus4_OUT,
    output logic                  ReadyfID_OUT,
    output logic [MISS_CNT_W-1:0] MissCount_OUT
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_MISS  = 1'b1
    } state_t;

    localparam logic [MISS_CNT_W-1:0] c_cnt_one = {{(MISS_CNT_W-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_nxt;
    logic [31:0]           r_pc, w_pc_nxt;
    logic [31:0]           r_instr, w_instr_nxt;
    logic [31:0]           r_instr_pc, w_instr_pc_nxt;
    logic [31:0]           r_instr_pc4, w_instr_pc4_nxt;
    logic                  r_nready, w_nready_nxt;
    logic                  r_redirect_used, w_redirect_used_nxt;
    logic [MISS_CNT_W-1:0] r_miss_cnt, w_miss_cnt_nxt;

    logic                  w_id_adv;
    logic                  w_redir;
    logic                  w_consumed;
    logic [31:0]           w_fetch_addr;

    assign w_id_adv     = !r_nready && !Stall_fmem_IN;
    assign w_redir      = Request_Alt_PC_IN && !r_redirect_used;
    assign w_fetch_addr = w_redir ? (Alt_PC_IN & ~32'h0000_0003) : r_pc;

    assign ICache_Addr_OUT    = (r_state == S_FETCH) ? w_fetch_addr : r_pc;
    assign ICache_Req_OUT     = (r_state == S_MISS);
    assign Instr1_OUT         = r_instr;
    assign Instr_PC_OUT       = r_instr_pc;
    assign Instr_PC_Plus4_OUT = r_instr_pc4;
    assign ReadyfID_OUT       = r_nready;
    assign MissCount_OUT      = r_miss_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_instr_pc4_nxt = r_instr_pc4;
        w_nready_nxt    = r_nready;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_consumed      = 1'b0;

        if (Stall_fmem_IN) begin
            // The fill keeps running under a data-cache stall; only its completion is taken.
            if (r_state == S_MISS && ICache_Fill_Done_IN) begin
                w_state_nxt = S_FETCH;
            end
        end else if (r_state == S_FETCH) begin
            if (WANT_FREEZE_IN) begin
                if (w_redir) begin
                    w_pc_nxt   = w_fetch_addr;
                    w_consumed = 1'b1;
                end
            end else if (ICache_Hit_IN) begin
                w_instr_nxt     = ICache_Data_IN;
                w_instr_pc_nxt  = w_fetch_addr;
                w_instr_pc4_nxt = w_fetch_addr + 32'd4;
                w_pc_nxt        = w_fetch_addr + 32'd4;
                w_nready_nxt    = 1'b0;
                w_consumed      = w_redir;
            end else begin
                w_pc_nxt       = w_fetch_addr;
                w_nready_nxt   = 1'b1;
                w_state_nxt    = S_MISS;
                w_miss_cnt_nxt = r_miss_cnt + c_cnt_one;
                w_consumed     = w_redir;
            end
        end else if (ICache_Fill_Done_IN) begin
            w_state_nxt = S_FETCH;
        end

        // Decode may hold its redirect request while waiting; apply it only once.
        if (w_id_adv) begin
            w_redirect_used_nxt = 1'b0;
        end else if (w_consumed) begin
            w_redirect_used_nxt = 1'b1;
        end else begin
            w_redirect_used_nxt = r_redirect_used;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_instr         <= 32'h0;
            r_instr_pc      <= 32'h0;
            r_instr_pc4     <= 32'h0;
            r_nready        <= 1'b1;
            r_redirect_used <= 1'b0;
            r_miss_cnt      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_instr         <= w_instr_nxt;
            r_instr_pc      <= w_instr_pc_nxt;
            r_instr_pc4     <= w_instr_pc4_nxt;
            r_nready        <= w_nready_nxt;
            r_redirect_used <= w_redirect_used_nxt;
            r_miss_cnt      <= w_miss_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : randomized bench for fetch_stage with a reference model |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] Alt_PC_IN = 32'h0;
    logic        Request_Alt_PC_IN = 1'b0;
    logic        WANT_FREEZE_IN = 1'b0;
    logic        Stall_fmem_IN = 1'b0;
    logic [31:0] ICache_Addr_OUT;
    logic        ICache_Req_OUT;
    logic [31:0] ICache_Data_IN;
    logic        ICache_Hit_IN;
    logic        ICache_Fill_Done_IN = 1'b0;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        ReadyfID_OUT;
    logic [31:0] MissCount_OUT;

    fetch_stage #(.RESET_PC(c_reset_pc), .MISS_CNT_W(32)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .Alt_PC_IN           (Alt_PC_IN),
        .Request_Alt_PC_IN   (Request_Alt_PC_IN),
        .WANT_FREEZE_IN      (WANT_FREEZE_IN),
        .Stall_fmem_IN       (Stall_fmem_IN),
        .ICache_Addr_OUT     (ICache_Addr_OUT),
        .ICache_Req_OUT      (ICache_Req_OUT),
        .ICache_Data_IN      (ICache_Data_IN),
        .ICache_Hit_IN       (ICache_Hit_IN),
        .ICache_Fill_Done_IN (ICache_Fill_Done_IN),
        .Instr1_OUT          (Instr1_OUT),
        .Instr_PC_OUT        (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT  (Instr_PC_Plus4_OUT),
        .ReadyfID_OUT        (ReadyfID_OUT),
        .MissCount_OUT       (MissCount_OUT)
    );

    initial forever #5 CLK = ~CLK;

    // Cache model: 16-byte lines, residency tracked per line index.
    bit          resident [256];
    bit          all_hit = 1'b1;
    logic [31:0] salt = 32'h0;

    always_comb begin
        ICache_Hit_IN  = all_hit || resident[ICache_Addr_OUT[11:4]];
        ICache_Data_IN = ICache_Addr_OUT ^ salt;
    end

    function automatic bit cache_hit(input logic [31:0] a);
        return all_hit || resident[a[11:4]];
    endfunction

    // Reference model of the architectural fetch state.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    bit          m_nready, m_used, m_miss;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = c_reset_pc; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
        m_nready = 1'b1; m_used = 1'b0; m_miss = 1'b0;
    endtask

    task automatic check_regs();
        chk("instr",     Instr1_OUT,         m_instr);
        chk("instr_pc",  Instr_PC_OUT,       m_ipc);
        chk("instr_pc4", Instr_PC_Plus4_OUT, m_ipc4);
        chk("ready",     32'(ReadyfID_OUT),  32'(m_nready));
        chk("misscount", MissCount_OUT,      m_cnt);
    endtask

    task automatic clear_cache();
        for (int i = 0; i < 256; i++) resident[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        Request_Alt_PC_IN = 1'b0;
        WANT_FREEZE_IN = 1'b0;
        Stall_fmem_IN = 1'b0;
        ICache_Fill_Done_IN = 1'b0;
        #1;
        chk("rst_req",   32'(ICache_Req_OUT), 32'h0);
        chk("rst_addr",  ICache_Addr_OUT,     c_reset_pc);
        chk("rst_cnt",   MissCount_OUT,       32'h0);
        chk("rst_ready", 32'(ReadyfID_OUT),   32'h1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
        check_regs();
    endtask

    // One clock: drive at negedge, check lookup, advance model, check registers.
    task automatic step(input bit stall, input bit freeze, input bit req,
                        input logic [31:0] alt, input bit fill);
        bit          redir, hit, consumed, id_adv, do_fill;
        logic [31:0] fa, exp_addr, fill_addr;
        @(negedge CLK);
        Stall_fmem_IN = stall;
        WANT_FREEZE_IN = freeze;
        Request_Alt_PC_IN = req;
        Alt_PC_IN = alt;
        ICache_Fill_Done_IN = fill;
        #1;
        redir    = req && !m_used;
        fa       = redir ? {alt[31:2], 2'b00} : m_pc;
        exp_addr = m_miss ? m_pc : fa;
        chk("icache_addr", ICache_Addr_OUT, exp_addr);
        chk("icache_req",  32'(ICache_Req_OUT), 32'(m_miss));
        hit       = cache_hit(exp_addr);
        id_adv    = !m_nready && !stall;
        consumed  = 1'b0;
        do_fill   = m_miss && fill;
        fill_addr = m_pc;
        @(posedge CLK);
        #1;
        if (stall) begin
            if (do_fill) m_miss = 1'b0;
        end else if (!m_miss) begin
            if (freeze) begin
                if (redir) begin m_pc = fa; consumed = 1'b1; end
            end else if (hit) begin
                m_instr = fa ^ salt; m_ipc = fa; m_ipc4 = fa + 32'd4;
                m_pc = fa + 32'd4; m_nready = 1'b0; consumed = redir;
            end else begin
                m_pc = fa; m_nready = 1'b1; m_miss = 1'b1;
                m_cnt = m_cnt + 32'd1; consumed = redir;
            end
        end else if (fill) begin
            m_miss = 1'b0;
        end
        if (id_adv) m_used = 1'b0;
        else if (consumed) m_used = 1'b1;
        if (do_fill) resident[fill_addr[11:4]] = 1'b1;
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    logic [31:0] saved_ipc, saved_instr;

    initial begin
        clear_cache();
        model_reset();
        do_reset();

        // Sequential hits with word = address.
        all_hit = 1'b1; salt = 32'h0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("seq_pc", Instr_PC_OUT, 32'(k * 4));
        end

        // Miss at 0x10, held for five cycles, then fill and lookup.
        all_hit = 1'b0; clear_cache();
        idle(1);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("miss_req",   32'(ICache_Req_OUT), 32'h1);
            chk("miss_ready", 32'(ReadyfID_OUT),   32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(1);
        chk("miss_pc",  Instr_PC_OUT,  32'h10);
        chk("miss_cnt", MissCount_OUT, 32'h1);

        // Redirect with unaligned target, then sequential.
        all_hit = 1'b1; salt = 32'h5A5A_0000;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("redir_pc", Instr_PC_OUT, 32'h100);
        idle(1);
        chk("redir_next", Instr_PC_OUT, 32'h104);

        // Request held while ReadyfID is high is applied only once.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("held_redir", Instr_PC_OUT, 32'h104);

        // Redirect to 0x200 that misses; request kept asserted throughout.
        all_hit = 1'b0; clear_cache();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        chk("redir_miss_addr", ICache_Addr_OUT, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        chk("redir_miss_pc", Instr_PC_OUT, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        chk("no_dup_pc", Instr_PC_OUT, 32'h204);

        // Freeze for four cycles with an always-hit cache.
        all_hit = 1'b1;
        idle(1);
        saved_ipc = m_ipc; saved_instr = m_instr;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("frz_pc",    Instr_PC_OUT, saved_ipc);
            chk("frz_instr", Instr1_OUT,   saved_instr);
        end

        // Stall arriving mid-miss; fill completes under the stall.
        all_hit = 1'b0; clear_cache();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0340, 1'b0);
        saved_ipc = m_ipc;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_hold", Instr_PC_OUT, saved_ipc);
        idle(1);
        chk("stall_after", Instr_PC_OUT, 32'h340);

        // Wrap at the top of the address space.
        all_hit = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(1);
        chk("wrap_pc", Instr_PC_OUT, 32'h0);

        // Reset while a fill is outstanding.
        all_hit = 1'b0; clear_cache();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0480, 1'b0);
        chk("pre_rst_req", 32'(ICache_Req_OUT), 32'h1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] alt;
            if (n % 300 == 0) all_hit = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) resident[$urandom_range(0, 255)] = 1'b0;
            salt = $urandom;
            alt = ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : (32'($urandom) & 32'h0000_0FFF);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, alt, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the architectural fetch PC and reads the instruction cache through a combinational hit/miss port.
- Delivers registered Instr/PC/PC+4 to decode and applies branch/jump redirects that decode issues.
- Honours decode's syscall freeze and the memory-stage stall; sequences instruction-cache misses through a two-state FSM.

Parameters:
RESET_PC, 32'h00000000, fetch PC loaded on reset
MISS_CNT_W, 32, width of miss counter

Ports:
CLK  input  1  clock; all state on posedge
RESET  input  1  asynchronous, active-low reset
Alt_PC_IN  input  32  redirect target (registered output of decode)
Request_Alt_PC_IN  input  1  redirect valid (registered output of decode)
WANT_FREEZE_IN  input  1  decode requests the PC to hold (syscall sequencing)
Stall_fmem_IN  input  1  data-cache stall; whole front end holds
ICache_Addr_OUT  output  32  cache lookup address (combinational)
ICache_Req_OUT  output  1  miss-fill request, held high for the whole fill
ICache_Data_IN  input  32  instruction word for ICache_Addr_OUT, same cycle
ICache_Hit_IN  input  1  ICache_Data_IN valid, same cycle
ICache_Fill_Done_IN  input  1  one-cycle pulse: line for ICache_Addr_OUT now resident
Instr1_OUT  output  32  instruction to decode
Instr_PC_OUT  output  32  PC of Instr1_OUT
Instr_PC_Plus4_OUT  output  32  Instr_PC_OUT+4
ReadyfID_OUT  output  1  1 = Instr1_OUT not valid, decode must hold (decode's polarity)
MissCount_OUT  output  MISS_CNT_W  number of misses since reset

Behaviour:
- Reset (async, RESET low):
  - PC_reg=RESET_PC; state=FETCH.
  - Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, MissCount_OUT = 0.
  - ReadyfID_OUT=1; redirect_used=0; ICache_Req_OUT=0.
  - Reset during MISS abandons the fill; Req drops immediately.
- Definitions:
  - ID_adv = !ReadyfID_OUT && !Stall_fmem_IN (decode consumes Instr1_OUT at this edge).
  - redir = Request_Alt_PC_IN && !redirect_used.
  - FetchAddr = redir ? {Alt_PC_IN[31:2],2'b00} : PC_reg.
- ICache_Addr_OUT = FetchAddr in FETCH; PC_reg in MISS.
- Edge priority, highest first:
  1. Stall_fmem_IN=1: all fetch registers hold; a MISS fill continues; Fill_Done is still honoured.
  2. WANT_FREEZE_IN=1 (FETCH):
     - Outputs and ReadyfID_OUT hold.
     - If redir, PC_reg<=FetchAddr and the redirect counts as consumed.
     - No cache access.
  3. FETCH, ICache_Hit_IN=1:
     - Instr1_OUT<=ICache_Data_IN; Instr_PC_OUT<=FetchAddr; Instr_PC_Plus4_OUT<=FetchAddr+4.
     - PC_reg<=FetchAddr+4 (32-bit wrap, FFFFFFFC->0); ReadyfID_OUT<=0.
  4. FETCH, hit=0:
     - PC_reg<=FetchAddr (captures the redirect); ReadyfID_OUT<=1; state<=MISS.
     - MissCount_OUT+=1 (wraps at max).
- MISS state:
  - ICache_Req_OUT=1; ReadyfID_OUT=1; outputs hold; Request_Alt_PC_IN ignored.
  - On ICache_Fill_Done_IN: state<=FETCH; the next cycle re-looks-up PC_reg.
  - Fill_Done in FETCH is ignored.
- redirect_used:
  - Set at an edge where a redirect was consumed (cases 2/3/4 with redir) and !ID_adv.
  - Cleared at any edge with ID_adv.
  - Prevents re-applying a redirect that decode keeps driving while it waits on ReadyfID_OUT.
- Delay slot: the instruction already in Instr1_OUT when decode resolves a branch is delivered normally; the redirect affects only the following fetch.
- Latency:
  - Hit: 1 cycle from address to Instr1_OUT.
  - Miss: Fill_Done edge, plus 1 lookup edge, then valid.
- Simultaneous freeze and miss: the freeze wins, no miss is started.
- Redirect arriving while in MISS is ignored. Decode cannot issue one then, because it is stalled.

Test Plan:
1. Reset, then always-hit cache returning word=addr: Instr_PC_OUT sequence 0,4,8,C; ReadyfID_OUT 1 then 0 from first edge; Plus4 = PC+4.
2. Redirect: at PC 8, pulse Request_Alt_PC_IN with Alt_PC_IN=0x100 (low bits 2'b11) -> next Instr_PC_OUT=0x100, then 0x104; a held Request while ReadyfID_OUT=1 is not re-applied.
3. Miss at 0x10: Req=1 and ReadyfID_OUT=1 for 5 cycles; Fill_Done -> one edge later Instr_PC_OUT=0x10, MissCount_OUT=1.
4. Redirect to 0x200 that misses: PC_reg=0x200 captured; after fill, Instr_PC_OUT=0x200; no duplicate 0x200 delivery.
5. WANT_FREEZE_IN=1 for 4 cycles with an always-hit cache -> outputs constant; Stall_fmem_IN=1 mid-miss -> fill completes, outputs unchanged until the stall drops.
6. RESET low during MISS -> Req=0 immediately, PC=RESET_PC, MissCount_OUT=0.
